// File: rtl/fw_rv_fifo_buffer_pkg.sv
// Shared definitions for the fw_rv_fifo_buffer slice: handshake encoding and
// pointer sizing helper.
package fw_rv_fifo_buffer_pkg;

  // {push, pop} for one cycle, as seen by the occupancy counter.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } rv_op_e;

  // Pointer width never drops to zero bits, even for a single entry.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fw_rv_wrap_ctr.sv
// Modulo-N pointer with synchronous clear and increment enable; wraps N-1 -> 0
// by explicit compare so non-power-of-two N works.
module fw_rv_wrap_ctr
  import fw_rv_fifo_buffer_pkg::*;
#(
  parameter int N = 4,
  parameter int W = ptr_width(N)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      value <= '0;
    end else if (inc) begin
      value <= (value == LAST) ? '0 : value + W'(1);
    end
  end

endmodule

// File: rtl/fw_rv_fifo_buffer.sv
// DEPTH-entry ready/valid FIFO with fill level, almost-full flag and
// synchronous flush; storage read combinationally at the head pointer.
module fw_rv_fifo_buffer
  import fw_rv_fifo_buffer_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           i_dat,
  input  logic                       i_valid,
  output logic                       i_ready,
  output logic [WIDTH-1:0]           o_dat,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_afull
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             pop_eff;
  rv_op_e           op;

  assign o_valid = (count != '0);
  assign pop     = o_valid & o_ready;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign i_ready = !flush & ((count < CNT_W'(DEPTH)) | pop);
  assign push    = i_valid & i_ready;
  assign pop_eff = pop & !flush;
  assign op      = rv_op_e'({push, pop_eff});

  assign o_dat   = mem[rd_ptr];
  assign o_count = count;
  assign o_afull = (count >= CNT_W'(AFULL_LEVEL));

  fw_rv_wrap_ctr #(.N(DEPTH), .W(PTR_W)) u_wr_ctr (
    .clock (clock),
    .reset (reset),
    .clear (flush),
    .inc   (push),
    .value (wr_ptr)
  );

  fw_rv_wrap_ctr #(.N(DEPTH), .W(PTR_W)) u_rd_ctr (
    .clock (clock),
    .reset (reset),
    .clear (flush),
    .inc   (pop_eff),
    .value (rd_ptr)
  );

  // NOTE: storage is reset so o_dat reads a defined 0 out of reset; flush
  // deliberately leaves the contents alone and only rewinds the pointers.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= i_dat;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      count <= '0;
    end else begin
      unique case (op)
        OP_PUSH: count <= count + CNT_W'(1);
        OP_POP:  count <= count - CNT_W'(1);
        OP_BOTH, OP_IDLE: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fw_rv_fifo_buffer.sv
// Scoreboard bench for fw_rv_fifo_buffer: DEPTH=4, DEPTH=3 and DEPTH=1
// instances driven with directed sequences, checked by per-instance monitors.
module tb_fw_rv_fifo_buffer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  int pops3       = 0;

  // DEPTH=4 instance
  logic       fl4 = 1'b0, iv4 = 1'b0, or4 = 1'b0;
  logic [7:0] id4 = '0;
  logic       ir4, ov4, af4;
  logic [7:0] od4;
  logic [2:0] cnt4;
  // DEPTH=3 instance
  logic       fl3 = 1'b0, iv3 = 1'b0, or3 = 1'b0;
  logic [7:0] id3 = '0;
  logic       ir3, ov3, af3;
  logic [7:0] od3;
  logic [1:0] cnt3;
  // DEPTH=1 instance
  logic       fl1 = 1'b0, iv1 = 1'b0, or1 = 1'b0;
  logic [7:0] id1 = '0;
  logic       ir1, ov1, af1;
  logic [7:0] od1;
  logic [0:0] cnt1;

  fw_rv_fifo_buffer #(.WIDTH(8), .DEPTH(4), .AFULL_LEVEL(3)) u_d4 (
    .clock(clock), .reset(reset), .flush(fl4), .i_dat(id4), .i_valid(iv4),
    .i_ready(ir4), .o_dat(od4), .o_valid(ov4), .o_ready(or4),
    .o_count(cnt4), .o_afull(af4));

  fw_rv_fifo_buffer #(.WIDTH(8), .DEPTH(3), .AFULL_LEVEL(2)) u_d3 (
    .clock(clock), .reset(reset), .flush(fl3), .i_dat(id3), .i_valid(iv3),
    .i_ready(ir3), .o_dat(od3), .o_valid(ov3), .o_ready(or3),
    .o_count(cnt3), .o_afull(af3));

  fw_rv_fifo_buffer #(.WIDTH(8), .DEPTH(1), .AFULL_LEVEL(1)) u_d1 (
    .clock(clock), .reset(reset), .flush(fl1), .i_dat(id1), .i_valid(iv1),
    .i_ready(ir1), .o_dat(od1), .o_valid(ov1), .o_ready(or1),
    .o_count(cnt1), .o_afull(af1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_underflow(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: output handshake with nothing expected", name);
  endtask

  // Inputs change 1ns after the rising edge; checks happen on the falling edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboards: accepted payloads queue up, output handshakes pop and compare.
  logic [7:0] q4[$];
  logic [7:0] q3[$];
  logic [7:0] q1[$];

  always @(negedge clock) begin
    if (reset || fl4) q4.delete();
    else begin
      if (ov4 && or4) begin
        if (q4.size() == 0) sb_underflow("d4 scoreboard");
        else check("d4 scoreboard", od4, q4.pop_front());
      end
      if (iv4 && ir4) q4.push_back(id4);
    end
  end

  always @(negedge clock) begin
    if (reset || fl3) q3.delete();
    else begin
      if (ov3 && or3) begin
        pops3++;
        if (q3.size() == 0) sb_underflow("d3 scoreboard");
        else check("d3 scoreboard", od3, q3.pop_front());
      end
      if (iv3 && ir3) q3.push_back(id3);
    end
  end

  always @(negedge clock) begin
    if (reset || fl1) q1.delete();
    else begin
      if (ov1 && or1) begin
        if (q1.size() == 0) sb_underflow("d1 scoreboard");
        else check("d1 scoreboard", od1, q1.pop_front());
      end
      if (iv1 && ir1) q1.push_back(id1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  fill_tbl [4];
    logic [31:0] stall_pat;
    int          sent;
    int          cyc;
    logic        accepted;
    fill_tbl  = '{8'h11, 8'h22, 8'h33, 8'h44};
    stall_pat = 32'b1011_0010_0111_0001_1100_1010_0110_1001;

    // Reset, then idle
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clock);
    check("d4 reset o_valid", ov4, 0);
    check("d4 reset o_count", cnt4, 0);
    check("d4 reset o_afull", af4, 0);
    check("d4 reset i_ready", ir4, 1);
    check("d4 reset o_dat",   od4, 0);
    check("d3 reset o_count", cnt3, 0);
    check("d1 reset o_valid", ov1, 0);
    check("d1 reset o_dat",   od1, 0);
    tick();

    // Fill DEPTH=4 with the downstream stalled
    for (int k = 0; k < 4; k++) begin
      iv4 = 1'b1; id4 = fill_tbl[k];
      @(negedge clock);
      check($sformatf("d4 fill count %0d", k), cnt4, k);
      check($sformatf("d4 fill afull %0d", k), af4, (k >= 3) ? 1 : 0);
      check($sformatf("d4 fill i_ready %0d", k), ir4, 1);
      tick();
    end
    id4 = 8'h55;
    @(negedge clock);
    check("d4 full count",   cnt4, 4);
    check("d4 full afull",   af4, 1);
    check("d4 full i_ready", ir4, 0);
    tick();
    iv4 = 1'b0; or4 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check($sformatf("d4 drain o_dat %0d", k), od4, fill_tbl[k]);
      check($sformatf("d4 drain count %0d", k), cnt4, 4 - k);
      tick();
    end
    @(negedge clock);
    check("d4 drained o_valid", ov4, 0);
    tick();

    // Full FIFO: simultaneous push and pop for 10 cycles
    or4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      iv4 = 1'b1; id4 = 8'(8'h80 + k);
      tick();
    end
    or4 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      id4 = 8'(8'h84 + k);
      @(negedge clock);
      check($sformatf("d4 stream i_ready %0d", k), ir4, 1);
      check($sformatf("d4 stream count %0d", k), cnt4, 4);
      check($sformatf("d4 stream o_dat %0d", k), od4, 8'h80 + k);
      tick();
    end
    iv4 = 1'b0;
    repeat (4) tick();
    @(negedge clock);
    check("d4 stream drained count", cnt4, 0);
    tick();

    // DEPTH=3 stream of 20 items against a fixed stall pattern
    sent = 0;
    cyc  = 0;
    while (sent < 20 && cyc < 300) begin
      iv3 = 1'b1; id3 = 8'(8'hA0 + sent); or3 = stall_pat[cyc % 32];
      @(negedge clock);
      accepted = ir3;
      if (cnt3 > 2'd3) check("d3 count bound", cnt3, 3);
      tick();
      if (accepted) sent++;
      cyc++;
    end
    iv3 = 1'b0; or3 = 1'b1;
    cyc = 0;
    while (cnt3 != 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    @(negedge clock);
    check("d3 items sent",   sent, 20);
    check("d3 items popped", pops3, 20);
    check("d3 final count",  cnt3, 0);
    tick();

    // Flush with two entries held and both handshakes requested
    or4 = 1'b0;
    iv4 = 1'b1; id4 = 8'hC0; tick();
    id4 = 8'hC1; tick();
    fl4 = 1'b1; id4 = 8'hC2; or4 = 1'b1;
    @(negedge clock);
    check("d4 flush count before", cnt4, 2);
    check("d4 flush i_ready", ir4, 0);
    tick();
    fl4 = 1'b0; iv4 = 1'b0; or4 = 1'b0;
    @(negedge clock);
    check("d4 post-flush count", cnt4, 0);
    check("d4 post-flush o_valid", ov4, 0);
    iv4 = 1'b1; id4 = 8'hC3;
    tick();
    iv4 = 1'b0; or4 = 1'b1;
    @(negedge clock);
    check("d4 post-flush head", od4, 8'hC3);
    check("d4 post-flush o_valid again", ov4, 1);
    tick();
    or4 = 1'b0;

    // DEPTH=1 at full throughput, then reset mid-stream
    iv1 = 1'b1; or1 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      id1 = 8'(8'hD0 + k);
      @(negedge clock);
      check($sformatf("d1 i_ready %0d", k), ir1, 1);
      if (k >= 1) begin
        check($sformatf("d1 o_valid %0d", k), ov1, 1);
        check($sformatf("d1 o_dat %0d", k), od1, 8'hD0 + k - 1);
        check($sformatf("d1 afull %0d", k), af1, 1);
      end
      tick();
    end
    reset = 1'b1;
    tick();
    @(negedge clock);
    check("d1 mid-reset o_valid", ov1, 0);
    check("d1 mid-reset o_count", cnt1, 0);
    check("d1 mid-reset o_afull", af1, 0);
    check("d1 mid-reset o_dat",   od1, 0);
    tick();
    reset = 1'b0; iv1 = 1'b0; or1 = 1'b0;
    tick();
    @(negedge clock);

    check("d4 scoreboard leftover", q4.size(), 0);
    check("d3 scoreboard leftover", q3.size(), 0);
    check("d1 scoreboard leftover", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fw_rv_fifo_buffer.md
Name: fw_rv_fifo_buffer

Overview:
- Parametrised multi-entry ready/valid buffer; successor to the single-entry registered buffer.
- Decouples an upstream initiator from a downstream target with DEPTH entries of storage.
- Adds fill-level reporting, a programmable almost-full flag and a synchronous flush.
- Sits on rv streams between pipeline stages or clock-enable domains; DEPTH=1 behaves exactly like a single-register rv buffer.

Parameters:
- WIDTH, 8, payload width in bits (>=1).
- DEPTH, 4, number of storage entries (>=1; non-power-of-two allowed).
- AFULL_LEVEL, DEPTH-1, count at or above which o_afull asserts (1..DEPTH).

Ports:
- clock  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of all entries.
- i_dat  input  WIDTH  upstream payload.
- i_valid  input  1  upstream payload valid.
- i_ready  output  1  buffer accepts i_dat this cycle.
- o_dat  output  WIDTH  head-of-queue payload.
- o_valid  output  1  head entry valid.
- o_ready  input  1  downstream accepts o_dat this cycle.
- o_count  output  $clog2(DEPTH+1)  number of occupied entries.
- o_afull  output  1  o_count >= AFULL_LEVEL.

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clock.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, o_valid=0, o_count=0, o_afull=0, and all storage entries=0, so o_dat=0.
- Handshakes:
  - push = i_valid & i_ready.
  - pop = o_valid & o_ready.
  - A transfer occurs only on a cycle where both signals are high.
- Outputs:
  - o_valid = (count != 0).
  - o_dat = mem[rd_ptr] (combinational read of registered storage); no combinational path from i_dat to o_dat.
  - o_count and o_afull are derived from count only; o_afull is combinational from count.
- i_ready = !flush & ((count < DEPTH) | pop).
  - When full, a push is accepted in the same cycle as a pop.
  - This creates a combinational path from o_ready to i_ready, which is intentional.
- Latency: data pushed in cycle N is visible on o_dat/o_valid in cycle N+1 at the earliest.
- Throughput: 1 transfer per cycle sustained for any DEPTH, including DEPTH=1 (push+pop in the same cycle when full).
- Pointer update:
  - push writes mem[wr_ptr] <= i_dat, then wr_ptr advances.
  - pop advances rd_ptr.
  - Both pointers wrap DEPTH-1 -> 0 with explicit compare, not power-of-two masking.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - Neither: unchanged.
- Boundary conditions:
  - Empty: o_valid=0; o_ready is ignored and no pop occurs.
  - Full: i_ready=0 unless a pop occurs this cycle.
  - Empty with a simultaneous push: no bypass; the entry appears next cycle.
- Flush:
  - Takes priority over push and pop.
  - Next cycle: wr_ptr=rd_ptr=0, count=0.
  - Storage is not cleared.
  - i_ready=0 while flush is high, so no upstream data is silently dropped.
  - A pop handshake in a flush cycle is not counted.
- Reset has priority over flush.
  - Reset mid-stream discards all entries.
  - Outputs return to reset values on the following cycle.
- The block performs no payload arithmetic; data is transported bit-exact.

Decomposition:
- No package types required. Payload is an opaque WIDTH vector.
- Count width constant CNT_W = $clog2(DEPTH+1) is a localparam; ptr width is max(1,$clog2(DEPTH)).
- Port bundles use the shared rv port macros header.
- Natural sub-module: fw_rv_wrap_ctr (parametrised modulo-N pointer with clear and increment enable), instantiated twice for wr_ptr and rd_ptr.

Test Plan:
- Reset then idle, WIDTH=8 DEPTH=4 -> o_valid=0, o_count=0, o_afull=0, i_ready=1, o_dat=0.
- Push 0x11,0x22,0x33,0x44 with o_ready=0 -> o_count reaches 4, o_afull=1 from count 3, i_ready=0 at count 4. Then set o_ready=1 -> outputs 0x11,0x22,0x33,0x44 in order, one per cycle.
- Full FIFO, i_valid=1 and o_ready=1 simultaneously for 10 cycles with incrementing data -> one transfer in and one out each cycle, o_count holds at 4, order preserved.
- DEPTH=3 (non-power-of-two), stream 20 items with random o_ready stalls -> pointers wrap correctly, no loss or duplication, scoreboard match.
- count=2, assert flush with i_valid=1 and o_ready=1 -> i_ready=0 that cycle, next cycle o_count=0 and o_valid=0, and the next push is the next item out.
- DEPTH=1, continuous i_valid and o_ready -> 100% throughput after the first cycle. Assert reset mid-stream -> all outputs at reset values the following cycle.
